// File: rtl/motor_drive_controller.sv
// Rover H-bridge driver: per-side PWM/direction from a user command, with crash back-off and latched halt.
// Optional build macro SOFT_START_EN ramps the applied duty by RAMP_STEP per PWM period while driving.
module motor_drive_controller #(
  parameter int PWM_BITS        = 8,
  parameter int PRESCALE        = 390,
  parameter int CRASH_FILT      = 1000,
  parameter int BACKOFF_PERIODS = 500,
  parameter int BACKOFF_DUTY    = 128,
  parameter int RAMP_STEP       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                is_crash,
  input  logic [1:0]          cmd_dir,
  input  logic [PWM_BITS-1:0] cmd_speed,
  output logic                pwm_l,
  output logic                pwm_r,
  output logic [1:0]          dir_l,
  output logic [1:0]          dir_r,
  output logic [1:0]          state_o,
  output logic                crash_seen
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CF_W = $clog2(CRASH_FILT + 1);
  localparam int BO_W = $clog2(BACKOFF_PERIODS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_DRIVE   = 2'b01,
    S_BACKOFF = 2'b10,
    S_HALT    = 2'b11
  } state_t;

  state_t              state_p0, state_d;
  logic [PS_W-1:0]     presc_p0;
  logic [PWM_BITS-1:0] pwm_cnt_p0;
  logic [PWM_BITS-1:0] duty_p0, duty_d;
  logic [3:0]          dir_p0, dir_d;
  logic [BO_W-1:0]     bo_cnt_p0, bo_cnt_d;
  logic [CF_W-1:0]     crash_cnt_p0;
  logic                pwm_p1;
  logic                restart;
  logic                tick, boundary, crash_evt;

  // {left IN1,IN2, right IN1,IN2} for a user direction command
  function automatic logic [3:0] dir_map(input logic [1:0] cmd);
    case (cmd)
      2'b01:   dir_map = 4'b1010;
      2'b10:   dir_map = 4'b0101;
      2'b11:   dir_map = 4'b1001;
      default: dir_map = 4'b0000;
    endcase
  endfunction

`ifdef SOFT_START_EN
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(RAMP_STEP);

  // Move one step toward the target, clamping so the target is never overshot
  function automatic logic [PWM_BITS-1:0] ramp_duty(input logic [PWM_BITS-1:0] cur,
                                                    input logic [PWM_BITS-1:0] tgt);
    if (cur < tgt)
      ramp_duty = ((tgt - cur) > STEP) ? cur + STEP : tgt;
    else if (cur > tgt)
      ramp_duty = ((cur - tgt) > STEP) ? cur - STEP : tgt;
    else
      ramp_duty = cur;
  endfunction
`endif

  assign tick      = (presc_p0 == PS_W'(PRESCALE - 1));
  assign boundary  = tick && (pwm_cnt_p0 == '1);
  assign crash_evt = is_crash && (crash_cnt_p0 == CF_W'(CRASH_FILT - 1));

  // Saturating filter: one event per continuous high run of is_crash
  always_ff @(posedge clk) begin
    if (reset || !is_crash)
      crash_cnt_p0 <= '0;
    else if (crash_cnt_p0 != CF_W'(CRASH_FILT))
      crash_cnt_p0 <= crash_cnt_p0 + 1'b1;
  end

  always_comb begin
    state_d  = state_p0;
    duty_d   = duty_p0;
    dir_d    = dir_p0;
    bo_cnt_d = bo_cnt_p0;
    restart  = 1'b0;
    case (state_p0)
      S_IDLE: begin
        if (cmd_dir != 2'b00) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        if (cmd_dir == 2'b00) begin
          state_d = S_IDLE;
          restart = 1'b1;
          duty_d  = '0;
          dir_d   = 4'b0000;
        end else if (crash_evt && cmd_dir[0]) begin
          // Sensor faces forward: only forward and spin react to a crash
          state_d  = S_BACKOFF;
          restart  = 1'b1;
          duty_d   = PWM_BITS'(BACKOFF_DUTY);
          dir_d    = 4'b0101;
          bo_cnt_d = '0;
        end else if (boundary) begin
          dir_d = dir_map(cmd_dir);
          if (dir_p0 != 4'b0000 && dir_map(cmd_dir) != dir_p0)
            duty_d = '0;
          else
`ifdef SOFT_START_EN
            duty_d = ramp_duty(duty_p0, cmd_speed);
`else
            duty_d = cmd_speed;
`endif
        end
      end
      S_BACKOFF: begin
        if (boundary) begin
          if (bo_cnt_p0 == BO_W'(BACKOFF_PERIODS - 1)) begin
            state_d  = S_HALT;
            restart  = 1'b1;
            duty_d   = '0;
            dir_d    = 4'b0000;
            bo_cnt_d = '0;
          end else begin
            bo_cnt_d = bo_cnt_p0 + 1'b1;
          end
        end
      end
      S_HALT: begin
        if (cmd_dir == 2'b00) begin
          state_d = S_IDLE;
          restart = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        restart = 1'b1;
        duty_d  = '0;
        dir_d   = 4'b0000;
      end
    endcase
  end

  // Stage p0: FSM, applied duty/direction, prescaler and PWM counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0   <= S_IDLE;
      duty_p0    <= '0;
      dir_p0     <= 4'b0000;
      bo_cnt_p0  <= '0;
      presc_p0   <= '0;
      pwm_cnt_p0 <= '0;
    end else begin
      state_p0  <= state_d;
      duty_p0   <= duty_d;
      dir_p0    <= dir_d;
      bo_cnt_p0 <= bo_cnt_d;
      if (restart) begin
        presc_p0   <= '0;
        pwm_cnt_p0 <= '0;
      end else begin
        presc_p0 <= tick ? '0 : presc_p0 + 1'b1;
        if (tick) pwm_cnt_p0 <= pwm_cnt_p0 + 1'b1;
      end
    end
  end

  // Stage p1: registered PWM compare
  always_ff @(posedge clk) begin
    if (reset || restart)
      pwm_p1 <= 1'b0;
    else
      pwm_p1 <= (pwm_cnt_p0 < duty_p0);
  end

  assign pwm_l      = pwm_p1;
  assign pwm_r      = pwm_p1;
  assign dir_l      = dir_p0[3:2];
  assign dir_r      = dir_p0[1:0];
  assign state_o    = state_p0;
  assign crash_seen = state_p0[1];

endmodule
